// File: rtl/data_sram_like_slave.sv
// Responder for the sram-like data bus: accepts read/write requests with an
// addr_ok handshake, performs them on a local word array, and returns one
// in-order data_ok per accepted request after a fixed or randomised latency.
module data_sram_like_slave #(
    parameter int unsigned AW      = 10,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned RAND_EN = 0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;
    // Wide enough for LATENCY-1 plus up to 7 random extra cycles.
    localparam int unsigned CW   = 5;

    logic [31:0]                mem_q [0:(1 << AW) - 1];
    logic [DEPTH-1:0][31:0]     data_q, data_d;
    logic [DEPTH-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]              head_q, head_d;
    logic [PW-1:0]              tail_q, tail_d;
    logic [CNTW-1:0]            count_q, count_d;
    logic [15:0]                lfsr_q, lfsr_d;

    logic [AW-1:0]              idx;
    logic                       push;
    logic                       pop;
    logic [CW-1:0]              new_cnt;
    logic                       unused_bits;

    // Size and the address bits outside the word index carry no meaning here.
    assign unused_bits = ^{data_sram_size, data_sram_addr};

    assign idx  = data_sram_addr[AW+1:2];
    assign push = data_sram_req && data_sram_addr_ok;
    assign pop  = data_sram_data_ok;

    // Handshake and response outputs; data_ok/rdata depend only on flops.
    always_comb begin
        data_sram_addr_ok = data_sram_req && !reset && (count_q != CNTW'(DEPTH)) &&
                            ((RAND_EN == 0) || lfsr_q[0]);
        data_sram_data_ok = (count_q != '0) && (cnt_q[head_q] == '0);
        data_sram_rdata   = data_sram_data_ok ? data_q[head_q] : 32'h0;
    end

    // Next state of the response queue and the LFSR.
    always_comb begin
        lfsr_d = lfsr_q;
        if (RAND_EN != 0) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end

        new_cnt = CW'(LATENCY - 1);
        if (RAND_EN != 0) begin
            new_cnt = new_cnt + CW'(lfsr_q[3:1]);
        end

        data_d = data_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
        end

        head_d = head_q;
        tail_d = tail_q;
        if (push) begin
            // Reads capture the pre-edge word; write responses carry zero.
            data_d[tail_q] = data_sram_wr ? 32'h0 : mem_q[idx];
            cnt_d[tail_q]  = new_cnt;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CNTW'(push) - CNTW'(pop);
    end

    // Queue, pointer and LFSR registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            lfsr_q  <= SEED;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Byte-enabled array write on an accepted write; contents survive reset.
    always_ff @(posedge clk) begin
        if (push && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem_q[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    a_no_dok_empty: assert property (@(posedge clk) disable iff (reset)
        data_sram_data_ok |-> (count_q != '0));
    a_count_max: assert property (@(posedge clk) disable iff (reset)
        count_q <= CNTW'(DEPTH));
    a_aok_needs_req: assert property (@(posedge clk) disable iff (reset)
        data_sram_addr_ok |-> data_sram_req);

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Directed bench for data_sram_like_slave: four instances cover latency 1, 3
// and 6 with fixed timing, plus a randomised instance checked by a scoreboard.
module tb_data_sram_like_slave;

    logic        clk;
    logic        reset;
    logic        req   [4];
    logic        wr    [4];
    logic [1:0]  size  [4];
    logic [31:0] addr  [4];
    logic [3:0]  wstrb [4];
    logic [31:0] wdata [4];
    logic        aok   [4];
    logic        dok   [4];
    logic [31:0] rdata [4];

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_sram_like_slave #(
            .AW      (10),
            .DEPTH   (4),
            .LATENCY ((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 6 : 2),
            .RAND_EN ((g == 3) ? 1 : 0),
            .SEED    (16'hACE1)
        ) u_dut (
            .clk               (clk),
            .reset             (reset),
            .data_sram_req     (req[g]),
            .data_sram_wr      (wr[g]),
            .data_sram_size    (size[g]),
            .data_sram_addr    (addr[g]),
            .data_sram_wstrb   (wstrb[g]),
            .data_sram_wdata   (wdata[g]),
            .data_sram_addr_ok (aok[g]),
            .data_sram_data_ok (dok[g]),
            .data_sram_rdata   (rdata[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on a fixed-latency instance; starts and ends #1 after a posedge.
    task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp, input int lat);
        int k;
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wstrb[i] = s; wdata[i] = d;
        @(negedge clk);
        check_eq("xfer_aok", 32'(aok[i]), 32'd1);
        @(posedge clk); #1;
        req[i] = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dok[i] && k < 40);
        check_eq("xfer_lat", 32'(k), 32'(lat));
        check_eq("xfer_rdata", rdata[i], exp);
        @(posedge clk); #1;
    endtask

    // Six back-to-back reads of 0x100.. with req held; per-cycle expectations in masks.
    task automatic stream(input int i, input int ncyc, input logic [15:0] am,
                          input logic [15:0] dm);
        int   nacc;
        int   nresp;
        logic acc;
        nacc = 0; nresp = 0;
        req[i] = 1'b1; wr[i] = 1'b0; wstrb[i] = 4'hF; addr[i] = 32'h100;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check_eq("strm_aok", 32'(aok[i]), 32'(am[c]));
            check_eq("strm_dok", 32'(dok[i]), 32'(dm[c]));
            if (dok[i]) begin
                check_eq("strm_rdata", rdata[i], 32'hC0DE_0000 + 32'(nresp));
                nresp++;
            end
            acc = req[i] && aok[i];
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc == 6) req[i] = 1'b0;
                else addr[i] = 32'h100 + 32'(4 * nacc);
            end
        end
        check_eq("strm_nresp", 32'(nresp), 32'd6);
    endtask

    logic [31:0] model [8];
    logic [31:0] exp_q [$];
    logic        cur_wr;
    int          cur_k;
    logic [3:0]  cur_strb;
    logic [31:0] cur_wdata;

    task automatic gen_op(input int nacc);
        if (nacc < 8) begin
            cur_wr = 1'b1; cur_k = nacc; cur_strb = 4'hF;
        end else begin
            cur_wr   = 1'($urandom_range(0, 1));
            cur_k    = int'($urandom_range(0, 7));
            cur_strb = 4'($urandom_range(1, 15));
        end
        cur_wdata = $urandom;
        wr[3]    = cur_wr;
        wstrb[3] = cur_strb;
        wdata[3] = cur_wdata;
        addr[3]  = (32'h200 + 32'(4 * cur_k)) | ($urandom & 32'hFFFF_F003);
    endtask

    // Randomised traffic on instance 3 against a byte-accurate scoreboard.
    task automatic rand_test();
        int   nacc;
        int   ndok;
        int   stalls;
        logic acc;
        logic done;
        nacc = 0; ndok = 0; stalls = 0; done = 1'b0;
        gen_op(0);
        req[3] = 1'b1;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            @(negedge clk);
            if (dok[3]) begin
                ndok++;
                if (exp_q.size() == 0) check_eq("rnd_spurious", 32'd1, 32'd0);
                else check_eq("rnd_rdata", rdata[3], exp_q.pop_front());
            end
            if (req[3] && !aok[3]) stalls++;
            acc = req[3] && aok[3];
            if (acc) begin
                if (cur_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (cur_strb[b]) model[cur_k][8*b +: 8] = cur_wdata[8*b +: 8];
                    end
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(model[cur_k]);
                end
                nacc++;
            end
            @(posedge clk); #1;
            if (acc || !req[3]) begin
                if (nacc < 200) begin
                    gen_op(nacc);
                    req[3] = ($urandom_range(0, 3) != 0);
                end else begin
                    req[3] = 1'b0;
                end
            end
            if (nacc == 200 && exp_q.size() == 0) done = 1'b1;
        end
        check_eq("rnd_acc", 32'(nacc), 32'd200);
        check_eq("rnd_dok", 32'(ndok), 32'd200);
        check_eq("rnd_stall", 32'(stalls != 0), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'd2;
            addr[i] = '0; wstrb[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle state after reset.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_aok", 32'(aok[i]), 32'd0);
            check_eq("rst_dok", 32'(dok[i]), 32'd0);
            check_eq("rst_rdata", rdata[i], 32'h0);
        end
        @(posedge clk); #1;

        // Latency 1: word write then read back.
        xfer(0, 1'b1, 32'h10, 4'hF, 32'h1234_5678, 32'h0, 1);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'h1234_5678, 1);

        // Byte and half-lane partial writes.
        xfer(0, 1'b1, 32'h20, 4'hF, 32'hAABB_CCDD, 32'h0, 1);
        xfer(0, 1'b1, 32'h20, 4'b0001, 32'h0000_00EE, 32'h0, 1);
        xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'hAABB_CCEE, 1);
        xfer(0, 1'b1, 32'h20, 4'b0110, 32'h1122_3344, 32'h0, 1);
        xfer(0, 1'b0, 32'h23, 4'hF, 32'h0, 32'hAA22_33EE, 1);

        // Back-to-back write then read of the same word.
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h14; wstrb[0] = 4'hF; wdata[0] = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("b2b_aok0", 32'(aok[0]), 32'd1);
        check_eq("b2b_dok0", 32'(dok[0]), 32'd0);
        @(posedge clk); #1;
        wr[0] = 1'b0;
        @(negedge clk);
        check_eq("b2b_aok1", 32'(aok[0]), 32'd1);
        check_eq("b2b_dok1", 32'(dok[0]), 32'd1);
        check_eq("b2b_wresp", rdata[0], 32'h0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        check_eq("b2b_aok2", 32'(aok[0]), 32'd0);
        check_eq("b2b_dok2", 32'(dok[0]), 32'd1);
        check_eq("b2b_rresp", rdata[0], 32'hCAFE_F00D);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("b2b_dok3", 32'(dok[0]), 32'd0);
        @(posedge clk); #1;

        // Preload 0x100..0x114 on the latency-3 and latency-6 instances.
        for (int k = 0; k < 6; k++) begin
            xfer(1, 1'b1, 32'h100 + 32'(4 * k), 4'hF, 32'hC0DE_0000 + 32'(k), 32'h0, 3);
            xfer(2, 1'b1, 32'h100 + 32'(4 * k), 4'hF, 32'hC0DE_0000 + 32'(k), 32'h0, 6);
        end

        // Latency 3: queue never fills, six pulses in cycles 3..8.
        stream(1, 10, 16'h003F, 16'h01F8);
        // Latency 6: fills after four accepts, stalls through the first pop cycle.
        stream(2, 15, 16'h018F, 16'h63C0);

        // Reset with two reads outstanding drops both responses.
        req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h100;
        @(posedge clk); #1;
        addr[2] = 32'h104;
        @(posedge clk); #1;
        req[2] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req[2] = 1'b1; addr[2] = 32'h104;
        @(negedge clk);
        check_eq("rstq_aok", 32'(aok[2]), 32'd1);
        check_eq("rstq_dok", 32'(dok[2]), 32'd0);
        @(posedge clk); #1;
        req[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("rstq_quiet", 32'(dok[2]), 32'd0);
        end
        @(negedge clk);
        check_eq("rstq_dok_new", 32'(dok[2]), 32'd1);
        check_eq("rstq_rdata", rdata[2], 32'hC0DE_0001);
        @(posedge clk); #1;

        rand_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
